// File: rtl/segment_pkg.sv
// rtl/segment_pkg.sv - shared types, constants and ASCII to 14-segment font for the scroller
package segment_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam int DIGITS     = 6;
  localparam int SEG_MSB    = 13;
  localparam int SEG_DP_BIT = 14;

  // Entries 0-9 are '0'..'9', entries 10-35 are 'A'..'Z'
  localparam logic [13:0] SEG_TABLE [36] = '{
    14'h0C3F, 14'h0006, 14'h00DB, 14'h008F, 14'h00E6,
    14'h2069, 14'h00FD, 14'h0007, 14'h00FF, 14'h00EF,
    14'h00F7, 14'h128F, 14'h0039, 14'h120F, 14'h00F9,
    14'h0071, 14'h00BD, 14'h00F6, 14'h1209, 14'h001E,
    14'h2470, 14'h0038, 14'h0536, 14'h2136, 14'h003F,
    14'h00F3, 14'h203F, 14'h20F3, 14'h00ED, 14'h1201,
    14'h003E, 14'h0C30, 14'h2836, 14'h2D00, 14'h1500,
    14'h0C09
  };

  function automatic logic [13:0] ascii_to_seg(input logic [6:0] code);
    logic [13:0] seg;
    seg = '0;
    if (code >= 7'h30 && code <= 7'h39)
      seg = SEG_TABLE[6'(code - 7'h30)];
    else if (code >= 7'h41 && code <= 7'h5A)
      seg = SEG_TABLE[6'(code - 7'h41) + 6'd10];
    else if (code >= 7'h61 && code <= 7'h7A)
      seg = SEG_TABLE[6'(code - 7'h61) + 6'd10];
    return seg;
  endfunction

endpackage

// File: rtl/char_to_segments.sv
// rtl/char_to_segments.sv - combinational buffer byte to 15-bit digit pattern
module char_to_segments
  import segment_pkg::*;
(
  input  logic [7:0]  i_char,
  output logic [14:0] o_pattern
);

  assign o_pattern[SEG_DP_BIT]  = i_char[7];
  assign o_pattern[SEG_MSB:0]   = ascii_to_seg(i_char[6:0]);

endmodule

// File: rtl/segment_scroller.sv
// rtl/segment_scroller.sv - message buffer and six-column static/scrolling window
module segment_scroller
  import segment_pkg::*;
#(
  parameter int MSG_DEPTH = 16,
  parameter int ADDR_W    = 4,
  parameter int TICK_DIV  = 500000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic [ADDR_W:0]   i_msg_len,
  input  logic              i_start,
  input  logic              i_stop,
  output logic              o_busy,
  output logic [14:0]       o_digit0,
  output logic [14:0]       o_digit1,
  output logic [14:0]       o_digit2,
  output logic [14:0]       o_digit3,
  output logic [14:0]       o_digit4,
  output logic [14:0]       o_digit5
);

  localparam int                  PRESC_W   = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [ADDR_W:0]     DEPTH_L   = (ADDR_W + 1)'(MSG_DEPTH);
  localparam logic [ADDR_W:0]     DIGITS_L  = (ADDR_W + 1)'(DIGITS);

  state_t              r_state, w_next_state;
  logic [7:0]          r_buf [MSG_DEPTH];
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W-1:0]   r_pos;
  logic [PRESC_W-1:0]  r_presc;
  logic [14:0]         r_digit [DIGITS];
  logic [14:0]         w_pat [DIGITS];
  logic                w_restart, w_scroll, w_tick;
  logic [ADDR_W:0]     w_len_clamped;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Stop has priority; a zero-length Start is a no-op in either state
  always_comb begin
    w_next_state = r_state;
    w_restart    = 1'b0;
    if (i_stop) begin
      w_next_state = ST_IDLE;
    end else if (i_start && (i_msg_len != '0)) begin
      w_next_state = ST_SHOW;
      w_restart    = 1'b1;
    end
  end

  assign w_len_clamped = (i_msg_len > DEPTH_L) ? DEPTH_L : i_msg_len;
  assign w_scroll      = (r_state == ST_SHOW) && (r_len > DIGITS_L);
  assign w_tick        = w_scroll && (r_presc == PRESC_MAX);
  assign o_busy        = (r_state == ST_SHOW);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len   <= '0;
      r_pos   <= '0;
      r_presc <= '0;
    end else if (w_restart) begin
      r_len   <= w_len_clamped;
      r_pos   <= '0;
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_pos   <= ({1'b0, r_pos} == r_len - 1'b1) ? '0 : r_pos + 1'b1;
    end else if (w_scroll) begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MSG_DEPTH; i++) r_buf[i] <= 8'h20;
    end else if (i_wr_en) begin
      r_buf[i_wr_addr] <= i_wr_data;
    end
  end

  // pos < len and k < 6 < len while scrolling, so one conditional subtract wraps the index
  for (genvar k = 0; k < DIGITS; k++) begin : g_col
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W-1:0] w_idx;
    logic              w_col_on;

    assign w_sum    = {1'b0, r_pos} + (ADDR_W + 1)'(k);
    assign w_idx    = ADDR_W'((w_sum >= r_len) ? (w_sum - r_len) : w_sum);
    assign w_col_on = ((ADDR_W + 1)'(k) < r_len);

    char_to_segments u_enc (
      .i_char    (r_buf[w_idx]),
      .o_pattern (w_pat[k])
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                  r_digit[k] <= '0;
      else if ((r_state == ST_SHOW) && w_col_on)  r_digit[k] <= w_pat[k];
      else                                        r_digit[k] <= '0;
    end
  end

  assign o_digit0 = r_digit[0];
  assign o_digit1 = r_digit[1];
  assign o_digit2 = r_digit[2];
  assign o_digit3 = r_digit[3];
  assign o_digit4 = r_digit[4];
  assign o_digit5 = r_digit[5];

endmodule

// File: tb/tb_segment_scroller.sv
// tb/tb_segment_scroller.sv - randomized bench for segment_scroller against a window/scroll model
module tb_segment_scroller;

  localparam int TICK = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [4:0]  msg_len = '0;
  logic        busy;
  logic [14:0] d0, d1, d2, d3, d4, d5;
  logic [14:0] dig [6];

  assign dig[0] = d0;
  assign dig[1] = d1;
  assign dig[2] = d2;
  assign dig[3] = d3;
  assign dig[4] = d4;
  assign dig[5] = d5;

  segment_scroller #(.MSG_DEPTH(DEPTH), .ADDR_W(4), .TICK_DIV(TICK)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_msg_len(msg_len), .i_start(start), .i_stop(stop), .o_busy(busy),
    .o_digit0(d0), .o_digit1(d1), .o_digit2(d2), .o_digit3(d3), .o_digit4(d4), .o_digit5(d5)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference: window contents derived from elapsed cycles since Start
  logic [7:0]  m_buf [DEPTH];
  bit          m_show;
  int          m_len, m_n;
  logic [14:0] exp_dig [6];
  bit          exp_busy;

  logic [13:0] font [36] = '{
    14'h0C3F, 14'h0006, 14'h00DB, 14'h008F, 14'h00E6, 14'h2069, 14'h00FD, 14'h0007, 14'h00FF, 14'h00EF,
    14'h00F7, 14'h128F, 14'h0039, 14'h120F, 14'h00F9, 14'h0071, 14'h00BD, 14'h00F6, 14'h1209, 14'h001E,
    14'h2470, 14'h0038, 14'h0536, 14'h2136, 14'h003F, 14'h00F3, 14'h203F, 14'h20F3, 14'h00ED, 14'h1201,
    14'h003E, 14'h0C30, 14'h2836, 14'h2D00, 14'h1500, 14'h0C09
  };

  function automatic logic [14:0] ref_enc(input logic [7:0] c);
    int a;
    a = int'(c[6:0]);
    if (a >= 48 && a <= 57)  return {c[7], font[6'(a - 48)]};
    if (a >= 65 && a <= 90)  return {c[7], font[6'(a - 55)]};
    if (a >= 97 && a <= 122) return {c[7], font[6'(a - 87)]};
    return {c[7], 14'h0000};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_buf[i] = 8'h20;
    m_show = 0; m_len = 0; m_n = 0; exp_busy = 0;
    for (int k = 0; k < 6; k++) exp_dig[k] = '0;
  endtask

  // One clock: expected outputs come from the state held before the edge
  task automatic step();
    int pos;
    for (int k = 0; k < 6; k++) begin
      if (!m_show)          exp_dig[k] = '0;
      else if (m_len <= 6)  exp_dig[k] = (k < m_len) ? ref_enc(m_buf[k]) : 15'h0;
      else begin
        pos = (m_n / TICK) % m_len;
        exp_dig[k] = ref_enc(m_buf[4'((pos + k) % m_len)]);
      end
    end
    if (wr_en) m_buf[wr_addr] = wr_data;
    if (stop) m_show = 0;
    else if (start && msg_len != 0) begin
      m_show = 1; m_len = (msg_len > 16) ? 16 : int'(msg_len); m_n = 0;
    end else if (m_show) m_n++;
    exp_busy = m_show;
    @(posedge clk); #1;
    wr_en = 0; start = 0; stop = 0;
  endtask

  task automatic write_byte(input int addr, input logic [7:0] data);
    wr_en = 1; wr_addr = 4'(addr); wr_data = data;
    step();
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (dig[k] !== 15'h0) begin errors++; $display("FAIL reset digit%0d got %h want 0000", k, dig[k]); end
    end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_static_hello();
    string s = "HELLO";
    for (int i = 0; i < 5; i++) write_byte(i, s[i]);
    msg_len = 5; start = 1;
    for (int c = 0; c < 22; c++) begin
      step();
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (dig[k] !== exp_dig[k]) begin errors++; $display("FAIL hello digit%0d cyc%0d got %h want %h", k, c, dig[k], exp_dig[k]); end
      end
      vectors++;
      if (busy !== exp_busy) begin errors++; $display("FAIL hello busy cyc%0d got %b want %b", c, busy, exp_busy); end
    end
  endtask

  task automatic test_scroll();
    string s = "ABCDEFGH";
    for (int i = 0; i < 8; i++) write_byte(i, s[i]);
    msg_len = 8; start = 1;
    for (int c = 0; c < 70; c++) begin
      step();
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (dig[k] !== exp_dig[k]) begin errors++; $display("FAIL scroll digit%0d cyc%0d got %h want %h", k, c, dig[k], exp_dig[k]); end
      end
      vectors++;
      if (busy !== exp_busy) begin errors++; $display("FAIL scroll busy cyc%0d got %b want %b", c, busy, exp_busy); end
    end
  endtask

  task automatic test_dp_lower();
    write_byte(0, 8'hB1);
    write_byte(1, 8'h61);
    msg_len = 2; start = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (dig[k] !== exp_dig[k]) begin errors++; $display("FAIL dp_lower digit%0d cyc%0d got %h want %h", k, c, dig[k], exp_dig[k]); end
      end
    end
    vectors++;
    if (d0 !== (15'h4000 | 15'h0006)) begin errors++; $display("FAIL dp_lower one_dp got %h want 4006", d0); end
    vectors++;
    if (d1 !== 15'h00F7) begin errors++; $display("FAIL dp_lower fold_a got %h want 00f7", d1); end
  endtask

  task automatic test_restart();
    write_byte(0, "A");
    write_byte(1, "B");
    msg_len = 8; start = 1;
    for (int c = 0; c < 30; c++) begin
      if (c == 13) begin msg_len = 8; start = 1; end
      if (c == 24) begin start = 1; stop = 1; end
      step();
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (dig[k] !== exp_dig[k]) begin errors++; $display("FAIL restart digit%0d cyc%0d got %h want %h", k, c, dig[k], exp_dig[k]); end
      end
      vectors++;
      if (busy !== exp_busy) begin errors++; $display("FAIL restart busy cyc%0d got %b want %b", c, busy, exp_busy); end
    end
  endtask

  task automatic test_len_edges();
    for (int c = 0; c < 200; c++) begin
      case (c)
        0:   begin msg_len = 0;  start = 1; end
        3:   begin msg_len = 6;  start = 1; end
        12:  begin msg_len = 7;  start = 1; end
        45:  begin msg_len = 0;  start = 1; end
        60:  begin stop = 1; end
        61:  begin msg_len = 0;  start = 1; end
        120: begin msg_len = 31; start = 1; end
        default: ;
      endcase
      if (c >= 62 && c < 78) begin
        wr_en = 1; wr_addr = 4'(c - 62);
        wr_data = (c % 2) ? 8'($urandom_range(65, 90)) : 8'($urandom_range(48, 57));
      end
      step();
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (dig[k] !== exp_dig[k]) begin errors++; $display("FAIL len_edge digit%0d cyc%0d got %h want %h", k, c, dig[k], exp_dig[k]); end
      end
      vectors++;
      if (busy !== exp_busy) begin errors++; $display("FAIL len_edge busy cyc%0d got %b want %b", c, busy, exp_busy); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 3) begin
        wr_en = 1; wr_addr = 4'($urandom_range(0, 15)); wr_data = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 99) < 4) begin start = 1; msg_len = 5'($urandom_range(0, 31)); end
      if ($urandom_range(0, 99) < 2) stop = 1;
      step();
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (dig[k] !== exp_dig[k]) begin errors++; $display("FAIL random digit%0d cyc%0d got %h want %h", k, c, dig[k], exp_dig[k]); end
      end
      vectors++;
      if (busy !== exp_busy) begin errors++; $display("FAIL random busy cyc%0d got %b want %b", c, busy, exp_busy); end
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 10; i++) write_byte(i, 8'($urandom_range(65, 90)));
    msg_len = 10; start = 1;
    for (int c = 0; c < 10; c++) step();
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrun pre_busy got %b want 1", busy); end
    #3 rst = 1;
    #1;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (dig[k] !== 15'h0) begin errors++; $display("FAIL midrun digit%0d got %h want 0000", k, dig[k]); end
    end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrun busy got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 0;
    msg_len = 6; start = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (dig[k] !== exp_dig[k]) begin errors++; $display("FAIL post_reset digit%0d cyc%0d got %h want %h", k, c, dig[k], exp_dig[k]); end
      end
      vectors++;
      if (busy !== exp_busy) begin errors++; $display("FAIL post_reset busy cyc%0d got %b want %b", c, busy, exp_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_static_hello();
    test_scroll();
    test_dp_lower();
    test_restart();
    test_len_edges();
    test_random();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
